req_arbiter8: RTL
=================

Name: req_arbiter8

Overview:
- Sequential 8-requester arbiter built around 8-to-3 priority selection.
- Shares one downstream resource (bus or datapath slot) among 8 requesters.
- Issues a one-hot grant plus its encoded index, holds the grant until the transaction completes or a hold limit expires, and provides an enable-in / enable-out pair for cascading arbiters.
- Sits between requester blocks and the shared resource; the only stateful control point for access.

Parameters:
RR_EN, 1, 1 = round-robin selection; 0 = fixed priority with bit 7 highest.
HOLD_MAX, 15, maximum cycles a grant may be held; 0 disables the timeout. Range 0..255.
CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
iClk  input  1  clock; all state updates on rising edge.
iRst  input  1  synchronous active-high reset.
iEI  input  1  enable in; 1 permits new grants.
iReq  input  8  request vector, bit i = requester i.
iDone  input  1  current grantee has finished its transaction.
oGrant  output  8  one-hot grant, registered.
oGrantIdx  output  3  encoded index of the granted requester, registered; 0 when no grant.
oValid  output  1  a grant is active, registered.
oPreempt  output  1  one-cycle pulse when a grant is revoked by timeout.
oEO  output  1  enable out, registered: arbiter idle, enabled and no requests.

Behaviour:
- Reset: on iRst high at an edge, the following all go to 0: state=IDLE, oGrant, oGrantIdx, oValid, oPreempt, oEO, rr pointer ptr, hold counter.
  - Reset overrides all other inputs, including mid-grant. The grant drops on the edge where iRst is sampled.
- States:
  - IDLE: no grant.
  - GRANT: grant held.
- IDLE → GRANT:
  - Taken when iEI=1 and |iReq=1 at an edge.
  - The winner is latched at that edge; oGrant, oGrantIdx and oValid become valid after that edge (1-cycle latency from sampled request).
  - Hold counter is cleared.
- Selection, RR_EN=1:
  - Search indices ptr, ptr+1, …, ptr+7 (mod 8); the first set bit wins.
  - When a grant ends, ptr <= (granted idx + 1) mod 8.
- Selection, RR_EN=0:
  - Highest set index wins; ptr is unused and stays 0.
- GRANT → IDLE, at the first edge with any of the following:
  - iDone=1;
  - iReq[idx]=0 (requester withdrew);
  - HOLD_MAX≠0 and hold counter == HOLD_MAX-1, i.e. the grant has lasted HOLD_MAX cycles.
- On exit from GRANT:
  - oGrant, oValid and oGrantIdx are cleared.
  - Every handover therefore includes at least one cycle with no grant.
- oPreempt:
  - Set for exactly one cycle when the exit was caused only by the timeout.
  - If iDone=1 or iReq[idx]=0 in the same cycle as the timeout, it is a normal release and oPreempt stays 0.
- Hold counter:
  - Increments every cycle in GRANT and saturates at its maximum.
  - Cleared on entry to GRANT.
- iEI:
  - iEI=0 blocks new grants only.
  - An active grant is not revoked by iEI=0 and completes normally.
- Grant stability:
  - oGrant/oGrantIdx are stable for the whole GRANT state.
  - Changes on iReq bits other than idx are ignored until the next arbitration.
- oEO:
  - Registered: oEO <= iEI & ~|iReq & (next state == IDLE).
  - Therefore oEO=0 whenever a grant is active or about to be issued.
- Single requester held high continuously with RR_EN=1:
  - Receives a grant, a 1-cycle gap, then is re-granted (pointer wraps back to it).
- Invariants:
  - oGrant is always one-hot or zero.
  - oGrant == (oValid ? 1<<oGrantIdx : 0).

Test Plan:
1. Reset then iEI=1, iReq=8'b00000100 → one edge later oGrant=8'b00000100, oGrantIdx=3'd2, oValid=1, oEO=0. Pulse iDone → next edge oGrant=0, oValid=0.
2. RR_EN=1, iReq=8'hFF held, iDone pulsed each grant → grant order idx 0,1,2,…,7,0 with one idle cycle between each; RR_EN=0 with same stimulus → idx 7 every time.
3. HOLD_MAX=4, iReq=8'b10000000, iDone never asserted → oValid high exactly 4 cycles, oPreempt=1 for 1 cycle on release; repeat with iDone=1 on the 4th cycle → oPreempt stays 0.
4. iEI=0, iReq=8'b00010000 → no grant, oEO=0. iEI=1, iReq=0 → oEO=1 after one edge. Drop iEI mid-grant → grant persists until iDone.
5. During GRANT to idx 5, assert iRst for one cycle → next edge all outputs 0, ptr=0. After release, iReq=8'b00100001 with RR_EN=1 → idx 0 granted.
6. During GRANT to idx 3, deassert iReq[3] while raising iReq[6] → release at next edge, 1 idle cycle, then grant idx 6. Assertion check of the one-hot/oGrantIdx invariant throughout.

Source files
------------

// File: rtl/req_arbiter8.sv
// req_arbiter8: 8-requester arbiter for one shared resource. Selects a winner by
// round-robin (RR_EN=1) or fixed priority with bit 7 highest (RR_EN=0), holds the
// grant until done, withdrawal or hold-limit timeout, and exposes enable-in /
// enable-out for cascading several arbiters.
module req_arbiter8 #(
  parameter int unsigned RR_EN    = 1,
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iEI,
  input  logic [7:0] iReq,
  input  logic       iDone,
  output logic [7:0] oGrant,
  output logic [2:0] oGrantIdx,
  output logic       oValid,
  output logic       oPreempt,
  output logic       oEO
);

  localparam int unsigned N         = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned HOLD_LAST = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
  localparam bit          HOLD_EN   = (HOLD_MAX != 0);
  localparam bit          RR_MODE   = (RR_EN != 0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [N-1:0]       r_grant;
  logic [IDX_W-1:0]   r_idx;
  logic               r_valid;
  logic               r_preempt;
  logic               r_eo;
  logic [IDX_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_hold_cnt;

  logic [N-1:0]       w_grant_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_valid_nxt;
  logic               w_preempt_nxt;
  logic               w_eo_nxt;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   w_hold_cnt_nxt;

  logic [2*N-1:0]     w_req_dbl;
  logic [N-1:0]       w_req_rot;
  logic [IDX_W-1:0]   w_rr_off;
  logic [IDX_W-1:0]   w_rr_idx;
  logic [IDX_W-1:0]   w_fp_idx;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_req_any;
  logic               w_start;
  logic               w_release_norm;
  logic               w_timeout;
  logic               w_end;

  // Rotate requests so the pointer position sits at bit 0 for the round-robin search
  assign w_req_dbl = {iReq, iReq};
  assign w_req_rot = w_req_dbl[r_ptr +: N];

  // Round-robin: lowest set bit of the rotated vector is the offset from the pointer
  always_comb begin
    w_rr_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_rr_off = IDX_W'(i);
    end
  end

  // Offset back into absolute index space; 3-bit add wraps mod 8
  assign w_rr_idx = r_ptr + w_rr_off;

  // Fixed priority: highest set request wins
  always_comb begin
    w_fp_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (iReq[i]) w_fp_idx = IDX_W'(i);
    end
  end

  assign w_sel_idx = RR_MODE ? w_rr_idx : w_fp_idx;

  // Arbitration and release conditions
  assign w_req_any      = |iReq;
  assign w_start        = (r_state == ST_IDLE) && iEI && w_req_any;
  assign w_release_norm = iDone || !iReq[r_idx];
  assign w_timeout      = HOLD_EN && (r_hold_cnt == CNT_W'(HOLD_LAST));
  assign w_end          = (r_state == ST_GRANT) && (w_release_norm || w_timeout);

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_end)   w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter
  always_comb begin
    w_grant_nxt    = r_grant;
    w_idx_nxt      = r_idx;
    w_valid_nxt    = r_valid;
    w_preempt_nxt  = 1'b0;
    w_ptr_nxt      = r_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_grant_nxt    = N'(1) << w_sel_idx;
          w_idx_nxt      = w_sel_idx;
          w_valid_nxt    = 1'b1;
          w_hold_cnt_nxt = '0;
        end
      end
      ST_GRANT: begin
        if (w_end) begin
          w_grant_nxt   = '0;
          w_idx_nxt     = '0;
          w_valid_nxt   = 1'b0;
          // Preemption only when the timeout alone ended the grant
          w_preempt_nxt = w_timeout && !w_release_norm;
          w_ptr_nxt     = RR_MODE ? (r_idx + IDX_W'(1)) : '0;
        end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
          w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
    // Cascade enable: idle next cycle, enabled and nobody asking
    w_eo_nxt = iEI && !w_req_any && (w_state_nxt == ST_IDLE);
  end

  // Output, pointer and hold-counter registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_grant    <= '0;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_preempt  <= 1'b0;
      r_eo       <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_grant    <= w_grant_nxt;
      r_idx      <= w_idx_nxt;
      r_valid    <= w_valid_nxt;
      r_preempt  <= w_preempt_nxt;
      r_eo       <= w_eo_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  assign oGrant    = r_grant;
  assign oGrantIdx = r_idx;
  assign oValid    = r_valid;
  assign oPreempt  = r_preempt;
  assign oEO       = r_eo;

endmodule
